div_5_bit_serializer: RTL and testbench
=======================================

Name: div_5_bit_serializer

Overview:
- Upstream feeder for div_5_detector: accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on in_bit.
- Idle cycles drive in_bit=0. Appending a 0 doubles the detector's running value, and since gcd(2,5)=1 the divisible-by-5 result is unchanged.
- Single clock domain; output registered; no internal buffering beyond one word.

Parameters:
- WORD_W, 8, width of each parallel input word (>=2); bit counter width is derived internally as $clog2(WORD_W).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- word_in  input  WORD_W  parallel word; sampled only on handshake.
- word_valid  input  1  word_in valid.
- word_ready  output  1  block can accept a word this cycle.
- in_bit  output  1  serial bit to div_5_detector.in_bit.
- bit_valid  output  1  in_bit carries a real data bit.
- word_last  output  1  current in_bit is the LSB of its word.
- busy  output  1  SHIFT state active.

Behaviour:
- Reset (rst_n low, async): state=SER_IDLE, shift reg=0, counter=0; in_bit=0, bit_valid=0, word_last=0, busy=0, word_ready=0. word_ready is forced low while rst_n is low.
- word_ready = rst_n && (state==SER_IDLE); with SER_BACK_TO_BACK_EN, also high during the word_last cycle.
- Handshake occurs on a rising edge with word_valid && word_ready:
  - Load shift reg with word_in.
  - Set counter to WORD_W-1.
  - state -> SER_SHIFT.
- word_valid without ready: no effect. word_in may change freely; it is never sampled outside a handshake.
- SER_SHIFT, per cycle:
  - in_bit = shreg[WORD_W-1].
  - bit_valid=1, busy=1.
  - word_last = (counter==0).
  - At each edge: shreg <<= 1 with 0 fill, counter--.
- Latency: the MSB appears on in_bit in the cycle immediately after the accepting edge. A word occupies exactly WORD_W consecutive cycles.
- Edge at which counter==0: with no new handshake, state -> SER_IDLE. Next cycle: in_bit=0, bit_valid=0, word_last=0, busy=0.
- SER_IDLE: in_bit held 0, bit_valid=0.
- Without SER_BACK_TO_BACK_EN, there is a minimum 1-cycle bubble between words.
- Reset mid-word: the word is dropped and outputs clear immediately. After release, the next accepted word starts from its MSB; no partial resume.
- No wrap-around risk: the counter only counts down from WORD_W-1 to 0, and reload happens only on handshake.

Optional Feature:
- Macro: SER_BACK_TO_BACK_EN.
- Defined:
  - word_ready is also asserted in the word_last cycle.
  - A handshake there reloads shreg/counter and stays in SER_SHIFT.
  - The next word's MSB follows the previous LSB with no bubble; bit_valid stays continuously high.
- Undefined:
  - word_ready is low throughout SER_SHIFT.
  - Every word is followed by at least one idle cycle (in_bit=0, bit_valid=0).

Decomposition:
- Shared package div_5_pkg holds:
  - typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_e.
  - localparam DIV_5_WORD_W_DEFAULT = 8.
- Single module; no sub-module (shift reg + down-counter + 2-state FSM is too small to split).
- Integration top instantiates div_5_bit_serializer feeding div_5_detector.

Test Plan:
1. Reset: hold rst_n=0 mid-run -> in_bit=0, bit_valid=0, word_last=0, busy=0, word_ready=0 immediately, without waiting for a clk edge.
2. Single word: 8'hA5 handshake -> in_bit 1,0,1,0,0,1,0,1 on 8 consecutive cycles. Then:
   - word_last only on cycle 8.
   - Cycle 9: bit_valid=0, word_ready=1.
3. Back-to-back: word_valid held with 8'h05 then 8'h0A.
   - Without macro: 8 bits, 1 bubble, 8 bits.
   - With SER_BACK_TO_BACK_EN: 16 consecutive bit_valid cycles, sequence 00000101_00001010.
4. Stall/ignore: toggle word_in randomly with word_valid=1 during SER_SHIFT -> word_ready=0 and serialized bits match the originally accepted word.
5. Mid-word reset: pulse rst_n low after 3 bits of 8'hFF, then send 8'h80 -> the 8'hFF stream truncates, and the output is 1,0,0,0,0,0,0,0 starting from the MSB.
6. Integration with div_5_detector: send 8'd15 -> div_5=1 after its LSB, and stays 1 through 5 idle zero cycles; send 8'd16 next -> div_5=0 after its LSB.

Source files
------------

// File: rtl/div_5_pkg.sv
// Shared types and defaults for the divisible-by-5 datapath (serializer and detector).
package div_5_pkg;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_e;

    localparam int DIV_5_WORD_W_DEFAULT = 8;

endpackage

// File: rtl/div_5_bit_serializer.sv
// Parallel-to-serial feeder for div_5_detector: accepts a word over valid/ready, shifts it out MSB-first.
// Optional macro SER_BACK_TO_BACK_EN lets a new word be accepted during the previous word's LSB cycle.
module div_5_bit_serializer
    import div_5_pkg::*;
#(
    parameter int WORD_W = DIV_5_WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              in_bit,
    output logic              bit_valid,
    output logic              word_last,
    output logic              busy
);

    localparam int              CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    ser_state_e        state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_shift;
    logic              is_last;
    logic              accept;

    assign in_shift = (state_q == SER_SHIFT);
    assign is_last  = in_shift && (cnt_q == '0);

    // Handshake: a word transfers on a rising edge where word_valid && word_ready.
    // word_ready never depends on word_valid, and is forced low while rst_n is low.
`ifdef SER_BACK_TO_BACK_EN
    assign word_ready = rst_n && (!in_shift || is_last);
`else
    assign word_ready = rst_n && !in_shift;
`endif

    assign accept = word_valid && word_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SER_SHIFT;
            shreg_d = word_in;
            cnt_d   = CNT_LAST;
        end else if (in_shift) begin
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            // Counter parks at zero once the word ends instead of wrapping.
            cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                state_d = SER_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only; idle cycles present in_bit=0.
    assign in_bit    = in_shift && shreg_q[WORD_W-1];
    assign bit_valid = in_shift;
    assign busy      = in_shift;
    assign word_last = is_last;

endmodule

// File: tb/tb_div_5_bit_serializer.sv
// Self-checking bench for div_5_bit_serializer: queue-based stream model plus directed literal checks.
module tb_div_5_bit_serializer;

    localparam int W = 8;
`ifdef SER_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] word_in;
    logic         word_valid;
    logic         word_ready;
    logic         in_bit;
    logic         bit_valid;
    logic         word_last;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    div_5_bit_serializer #(.WORD_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .in_bit     (in_bit),
        .bit_valid  (bit_valid),
        .word_last  (word_last),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each entry is one serial cycle the DUT still owes: {is_last, bit}.
    logic [1:0] exp_q[$];

    function automatic logic exp_ready();
        return rst_n && ((exp_q.size() == 0) || (B2B && exp_q.size() == 1));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            logic acc;
            acc = word_valid && exp_ready();
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) exp_q.push_back({(i == 0), word_in[i]});
            end
        end
    end

    // Running remainder a div_5_detector would hold, fed from the DUT stream.
    int rem;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rem <= 0;
        else        rem <= (rem * 2 + int'(in_bit)) % 5;
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            check("idle_bit_valid", bit_valid, 0);
            check("idle_in_bit", in_bit, 0);
            check("idle_word_last", word_last, 0);
            check("idle_busy", busy, 0);
        end else begin
            check("shift_bit_valid", bit_valid, 1);
            check("shift_in_bit", in_bit, exp_q[0][0]);
            check("shift_word_last", word_last, exp_q[0][1]);
            check("shift_busy", busy, 1);
        end
        check("word_ready", word_ready, exp_ready());
    end

    // Cycle trace of {bit_valid, in_bit} for sequence checks.
    bit         cap_en = 1'b0;
    logic [1:0] cap_q[$];
    always @(negedge clk) begin
        if (cap_en) cap_q.push_back({bit_valid, in_bit});
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge of the word's MSB cycle.
    task automatic send(input logic [W-1:0] w, input bit hold);
        int n;
        word_in    = w;
        word_valid = 1'b1;
        n = 0;
        while (!word_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!word_ready) begin
            check("send_timeout", 1, 0);
            word_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (!hold) word_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_outputs_clear(input string name);
        check({name, "_in_bit"}, in_bit, 0);
        check({name, "_bit_valid"}, bit_valid, 0);
        check({name, "_word_last"}, word_last, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_word_ready"}, word_ready, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pat;
        logic [7:0] w1;
        logic [7:0] w2;
        logic [1:0] exp_seq[$];
        int         s;

        rst_n      = 1'b0;
        word_valid = 1'b0;
        word_in    = '0;
        repeat (2) @(negedge clk);
        check_outputs_clear("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single word 8'hA5, MSB first, word_last only on the 8th cycle.
        pat = 8'hA5;
        send(pat, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("a5_in_bit", in_bit, pat[7 - i]);
            check("a5_word_last", word_last, (i == 7));
            check("a5_bit_valid", bit_valid, 1);
            @(negedge clk);
        end
        check("a5_after_bit_valid", bit_valid, 0);
        check("a5_after_ready", word_ready, 1);
        @(negedge clk);

        // Back-to-back with word_valid held.
        w1 = 8'h05;
        w2 = 8'h0A;
        cap_q.delete();
        cap_en = 1'b1;
        send(w1, 1'b1);
        send(w2, 1'b0);
        repeat (12) @(negedge clk);
        cap_en = 1'b0;
        for (int i = 7; i >= 0; i--) exp_seq.push_back({1'b1, w1[i]});
        if (!B2B) exp_seq.push_back(2'b00);
        for (int i = 7; i >= 0; i--) exp_seq.push_back({1'b1, w2[i]});
        exp_seq.push_back(2'b00);
        s = -1;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (s < 0 && cap_q[i][1]) s = i;
        end
        if (s < 0 || s + exp_seq.size() > cap_q.size()) begin
            check("b2b_capture", 0, 1);
        end else begin
            for (int i = 0; i < exp_seq.size(); i++) check("b2b_seq", cap_q[s + i], exp_seq[i]);
        end

        // Stall: word_in churns with word_valid high while shifting.
        send(8'(($urandom)), 1'b1);
        for (int i = 1; i < W; i++) begin
            check("stall_ready", word_ready, 0);
            word_in = 8'($urandom);
            @(negedge clk);
        end
        word_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Mid-word reset after 3 bits of 8'hFF, then 8'h80 from its MSB.
        send(8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_clear("midreset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pat = 8'h80;
        send(pat, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("x80_in_bit", in_bit, pat[7 - i]);
            check("x80_bit_valid", bit_valid, 1);
            @(negedge clk);
        end
        check("x80_after_bit_valid", bit_valid, 0);

        // Detector view: 15 is divisible by 5, trailing zeros keep it so; 16 appended is not.
        pulse_reset();
        send(8'd15, 1'b0);
        repeat (7) @(negedge clk);
        @(negedge clk);
        check("div5_after_15", (rem == 0), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("div5_idle_zeros", (rem == 0), 1);
        end
        send(8'd16, 1'b0);
        repeat (7) @(negedge clk);
        @(negedge clk);
        check("div5_after_16", (rem == 0), 0);

        // Randomized traffic with occasional resets; the scoreboard checks every cycle.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            word_valid = ($urandom_range(0, 3) != 0);
            word_in    = 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        word_valid = 1'b0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
